// File: rtl/bean_mem_pkg.sv
// Shared definitions for the BEAN-1 memory front end: access modes, FSM states
// and the mode/alignment legality check.
package bean_mem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR,
        RESP
    } state_t;

    // True when the mode is a defined encoding and the address is naturally aligned for it.
    function automatic logic access_ok(input logic [2:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MODE_B, MODE_BU: return 1'b1;
            MODE_H, MODE_HU: return !addr_lo[0];
            MODE_W:          return (addr_lo == 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after i_ptr
// (cyclic) wins.
module rr_arbiter #(
    parameter int N_CH = 2,
    localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [N_CH-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            int c;
            c = (int'(i_ptr) + i) % N_CH;
            if (!w_found && i_req[c]) begin
                w_found = 1'b1;
                w_idx   = IW'(c);
            end
        end
    end

    assign o_gnt = N_CH'(w_found) << w_idx;
    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-channel front end onto the single BEAN-1 memory port: round-robin grant,
// alignment check, issue, optional read wait, registered completion.
module mem_port_arbiter
    import bean_mem_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int AW     = 32,
    parameter int RD_LAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      m_req,
    input  logic [N_CH-1:0]      m_we,
    input  logic [3*N_CH-1:0]    m_mode,
    input  logic [AW*N_CH-1:0]   m_addr,
    input  logic [32*N_CH-1:0]   m_wdata,
    output logic [N_CH-1:0]      m_gnt,
    output logic [N_CH-1:0]      m_done,
    output logic                 m_err,
    output logic [31:0]          m_rdata,
    output logic [AW-1:0]        mem_addrs,
    output logic [2:0]           mem_MODE,
    output logic                 mem_WE,
    output logic [31:0]          data_mem_WRITE,
    input  logic [31:0]          data_mem_READ
);

    localparam int         IW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [2:0] LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_t        r_state, w_next;
    logic [IW-1:0] r_rr_ptr, r_ch;
    logic [2:0]    r_cnt;
    logic          r_we, r_err;
    logic [2:0]    r_mode;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata, r_rdata;

    logic [N_CH-1:0] w_arb_gnt;
    logic [IW-1:0]   w_win;
    logic            w_any;
    logic            w_win_we;
    logic [2:0]      w_win_mode;
    logic [AW-1:0]   w_win_addr;
    logic [31:0]     w_win_wdata;
    logic            w_win_ok;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req (m_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_win),
        .o_any (w_any)
    );

    assign w_win_we    = m_we[w_win];
    assign w_win_mode  = m_mode[3*int'(w_win) +: 3];
    assign w_win_addr  = m_addr[AW*int'(w_win) +: AW];
    assign w_win_wdata = m_wdata[32*int'(w_win) +: 32];
    assign w_win_ok    = access_ok(w_win_mode, w_win_addr[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        m_gnt  = '0;
        m_done = '0;
        m_err  = 1'b0;
        mem_WE = 1'b0;
        case (r_state)
            IDLE: begin
                m_gnt = w_arb_gnt;
                if (w_any) w_next = w_win_ok ? ISSUE : ERR;
            end
            ISSUE: begin
                mem_WE = r_we;
                w_next = (r_we || RD_LAT == 0) ? RESP : WAIT;
            end
            WAIT:    if (r_cnt == 3'd0) w_next = RESP;
            ERR:     w_next = RESP;
            RESP: begin
                m_done = N_CH'(1) << r_ch;
                m_err  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Captured request is held in place so memory sees stable values through ISSUE/WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_ch     <= '0;
            r_cnt    <= 3'd0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_mode   <= MODE_W;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_ch     <= w_win;
                    r_we     <= w_win_we;
                    r_err    <= !w_win_ok;
                    r_mode   <= w_win_mode;
                    r_addr   <= w_win_addr;
                    r_wdata  <= w_win_wdata;
                    r_rr_ptr <= (w_win == IW'(N_CH - 1)) ? '0 : w_win + 1'b1;
                end
                ISSUE: if (!r_we) begin
                    if (RD_LAT == 0) r_rdata <= data_mem_READ;
                    else             r_cnt   <= LAT_LOAD;
                end
                WAIT: begin
                    if (r_cnt == 3'd0) r_rdata <= data_mem_READ;
                    else               r_cnt   <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_rdata        = r_rdata;
    assign mem_addrs      = r_addr;
    assign mem_MODE       = r_mode;
    assign data_mem_WRITE = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with RD_LAT=0, one with RD_LAT=3,
// each backed by a small lane-aware memory model.
module tb_mem_port_arbiter;

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req[2], we[2], gnt[2], done[2];
    logic [5:0]  mode[2];
    logic [63:0] addr[2], wdata[2];
    logic        err[2], mwe[2];
    logic [31:0] rdata[2], maddr[2], mwd[2], mrd[2], scr[2];
    logic [2:0]  mmode[2];
    logic [31:0] mem[2][0:255];

    exp_t q0[$], q1[$];
    int   n_run = 0, n_fail = 0;
    int   ndone[2];

    mem_port_arbiter #(.N_CH(2), .AW(32), .RD_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .m_req(req[0]), .m_we(we[0]), .m_mode(mode[0]),
        .m_addr(addr[0]), .m_wdata(wdata[0]), .m_gnt(gnt[0]), .m_done(done[0]),
        .m_err(err[0]), .m_rdata(rdata[0]), .mem_addrs(maddr[0]), .mem_MODE(mmode[0]),
        .mem_WE(mwe[0]), .data_mem_WRITE(mwd[0]), .data_mem_READ(mrd[0])
    );

    mem_port_arbiter #(.N_CH(2), .AW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .m_req(req[1]), .m_we(we[1]), .m_mode(mode[1]),
        .m_addr(addr[1]), .m_wdata(wdata[1]), .m_gnt(gnt[1]), .m_done(done[1]),
        .m_err(err[1]), .m_rdata(rdata[1]), .mem_addrs(maddr[1]), .mem_MODE(mmode[1]),
        .mem_WE(mwe[1]), .data_mem_WRITE(mwd[1]), .data_mem_READ(mrd[1])
    );

    function automatic logic [31:0] rd_lane(input logic [31:0] w, input logic [2:0] md,
                                            input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (md[1:0])
            2'b00:   return md[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return md[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] wr_lane(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] md, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        case (md[1:0])
            2'b00:   r[{a, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign mrd[0] = rd_lane(mem[0][maddr[0][9:2]], mmode[0], maddr[0][1:0]) ^ scr[0];
    assign mrd[1] = rd_lane(mem[1][maddr[1][9:2]], mmode[1], maddr[1][1:0]) ^ scr[1];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (mwe[d]) mem[d][maddr[d][9:2]] <= wr_lane(mem[d][maddr[d][9:2]], mwd[d], mmode[d], maddr[d][1:0]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_run++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a completion appears.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (gnt[d] != 2'b00) chk("gnt_onehot", {31'b0, $onehot(gnt[d])}, 32'd1);
            if (err[d] && done[d] == 2'b00) chk("err_without_done", {31'b0, err[d]}, 32'd0);
            if (done[d] != 2'b00) begin
                ndone[d]++;
                chk("done_onehot", {31'b0, $onehot(done[d])}, 32'd1);
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_done", {30'b0, done[d]}, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("done_ch", {30'b0, done[d]}, 32'd1 << e.ch);
                    chk("done_err", {31'b0, err[d]}, {31'b0, e.err});
                    chk("done_rdata", rdata[d], e.rd);
                end
            end
        end
    end

    task automatic set_ch(input int d, input int ch, input logic w, input logic [2:0] md,
                          input logic [31:0] a, input logic [31:0] wd);
        we[d][ch]           = w;
        mode[d][3*ch +: 3]  = md;
        addr[d][32*ch +: 32]  = a;
        wdata[d][32*ch +: 32] = wd;
        req[d][ch]          = 1'b1;
    endtask

    task automatic chk_rst(input int d);
        chk("rst_gnt",   {30'b0, gnt[d]},  32'd0);
        chk("rst_done",  {30'b0, done[d]}, 32'd0);
        chk("rst_err",   {31'b0, err[d]},  32'd0);
        chk("rst_rdata", rdata[d],         32'd0);
        chk("rst_we",    {31'b0, mwe[d]},  32'd0);
        chk("rst_addr",  maddr[d],         32'd0);
        chk("rst_mode",  {29'b0, mmode[d]}, 32'd2);
        chk("rst_wdata", mwd[d],           32'd0);
    endtask

    // One transaction on instance d; read data is only correct in the cycle the
    // DUT is supposed to capture it (scramble applied otherwise).
    task automatic txn(input int d, input int ch, input logic w, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rd, input int lat, input bit abort);
        int k, n, wec, weoff, cap, explat;
        exp_t e;
        cap    = (w || e_err) ? -1 : lat + 1;
        explat = (w || e_err) ? 2 : lat + 2;
        @(negedge clk);
        set_ch(d, ch, w, md, a, wd);
        scr[d] = 32'hA5A50F0F;
        #1;
        k = 0;
        while (!gnt[d][ch] && k < 20) begin @(negedge clk); k++; end
        if (!gnt[d][ch]) begin
            chk("grant_timeout", 32'd0, 32'd1);
            req[d][ch] = 1'b0;
            return;
        end
        if (!abort) begin
            e.ch = ch; e.err = e_err; e.rd = e_rd;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        n = 0; wec = 0; weoff = -1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            scr[d] = (n == cap) ? 32'd0 : 32'hA5A50F0F;
            if (mwe[d]) begin wec++; weoff = n; end
            if (abort && n == 3) begin
                reset  = 1'b0;
                req[d] = 2'b00;
                #1;
                chk_rst(d);
                break;
            end
            if (done[d][ch]) break;
        end
        if (abort) begin
            repeat (2) @(negedge clk);
            reset = 1'b1;
            return;
        end
        chk("latency", n, explat);
        chk("we_count", wec, {31'b0, w && !e_err});
        if (wec != 0) chk("we_cycle", weoff, 32'd1);
        req[d][ch] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, nd;
        exp_t e;
        reset = 1'b0;
        ndone[0] = 0; ndone[1] = 0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; we[d] = '0; mode[d] = '0; addr[d] = '0; wdata[d] = '0; scr[d] = '0;
            for (int i = 0; i < 256; i++) mem[d][i] = 32'h0;
            mem[d][8'h40] = 32'hDEADBEEF;
            mem[d][8'h41] = 32'h12345678;
            mem[d][8'h80] = 32'h11223344;
        end
        repeat (2) @(negedge clk);
        #1;
        chk_rst(0);
        chk_rst(1);
        reset = 1'b1;

        // RD_LAT=0 basic read, then ch1 read wraps the pointer back to 0.
        txn(0, 0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        txn(0, 1, 1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'h12345678, 0, 1'b0);

        // Continuous simultaneous requests must alternate.
        @(negedge clk);
        scr[0] = 32'd0;
        set_ch(0, 0, 1'b0, 3'b010, 32'h100, 32'h0);
        set_ch(0, 1, 1'b0, 3'b010, 32'h104, 32'h0);
        #1;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (gnt[0] == 2'b00 && k < 20) begin @(negedge clk); k++; end
            chk("alt_grant", {30'b0, gnt[0]}, 32'd1 << (g % 2));
            e.ch = g % 2; e.err = 1'b0; e.rd = (g % 2) ? 32'h12345678 : 32'hDEADBEEF;
            q0.push_back(e);
            @(negedge clk);
        end
        @(negedge clk);
        req[0] = 2'b00;

        // Error paths: misaligned word, misaligned half, illegal mode as a write.
        txn(0, 1, 1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h12345678, 0, 1'b0);
        txn(0, 1, 1'b0, 3'b001, 32'h103, 32'h0,        1'b1, 32'h12345678, 0, 1'b0);
        txn(0, 1, 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h12345678, 0, 1'b0);
        txn(0, 0, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 0, 1'b0);

        // Byte write then reads with each extension flavour.
        txn(0, 0, 1'b1, 3'b000, 32'h200, 32'h000000A5, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        txn(0, 0, 1'b0, 3'b100, 32'h200, 32'h0,        1'b0, 32'h000000A5, 0, 1'b0);
        txn(0, 0, 1'b0, 3'b000, 32'h200, 32'h0,        1'b0, 32'hFFFFFFA5, 0, 1'b0);
        txn(0, 0, 1'b0, 3'b001, 32'h202, 32'h0,        1'b0, 32'h00001122, 0, 1'b0);
        txn(0, 0, 1'b0, 3'b010, 32'h200, 32'h0,        1'b0, 32'h112233A5, 0, 1'b0);

        // RD_LAT=3 read, then a read aborted by reset in WAIT.
        txn(1, 0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b0);
        txn(1, 0, 1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'h0,        3, 1'b1);
        nd = ndone[1];
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", ndone[1], nd);

        // After reset the pointer is 0: ch0 beats ch1.
        @(negedge clk);
        scr[1] = 32'd0;
        set_ch(1, 1, 1'b0, 3'b010, 32'h104, 32'h0);
        set_ch(1, 0, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        chk("post_rst_grant", {30'b0, gnt[1]}, 32'd1);
        e.ch = 0; e.err = 1'b0; e.rd = 32'hDEADBEEF; q1.push_back(e);
        e.ch = 1; e.err = 1'b0; e.rd = 32'h12345678; q1.push_back(e);
        k = 0;
        while (!done[1][0] && k < 20) begin @(negedge clk); k++; end
        req[1][0] = 1'b0;
        k = 0;
        while (!done[1][1] && k < 20) begin @(negedge clk); k++; end
        chk("post_rst_ch1_done", {31'b0, done[1][1]}, 32'd1);
        req[1][1] = 1'b0;

        repeat (4) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Multi-channel memory front end between N requesters (instruction fetch, data load/store, debug/DMA) and the single shared memory port of the BEAN-1 system.
- Each transaction is arbitrated round-robin, alignment-checked against its access mode, issued to memory, and answered with a registered completion after a configurable read latency.
- Replaces the direct CPU-to-memory wiring in the top level.

Parameters:
- N_CH, 2, number of requesting channels (1..8).
- AW, 32, address width.
- RD_LAT, 0, memory read latency in cycles after the issue cycle (0..7); 0 means a combinational-read memory.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  N_CH  per-channel request; held until that channel's m_done.
- m_we  in  N_CH  per-channel write enable.
- m_mode  in  3*N_CH  per-channel access mode, slice [3i+2:3i].
- m_addr  in  AW*N_CH  per-channel address.
- m_wdata  in  32*N_CH  per-channel write data.
- m_gnt  out  N_CH  one-hot acceptance strobe.
- m_done  out  N_CH  one-hot completion pulse.
- m_err  out  1  valid with m_done; transaction rejected.
- m_rdata  out  32  read data, valid with m_done for reads.
- mem_addrs  out  AW  memory address.
- mem_MODE  out  3  memory access mode.
- mem_WE  out  1  memory write enable.
- data_mem_WRITE  out  32  memory write data.
- data_mem_READ  in  32  memory read data.

Behaviour:
- Mode encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned. The block passes mode through; memory does the lane/extension work.
- Illegal modes (011, 110, 111) are errors.
- Misalignment errors: half-size modes with addr[0]=1; word with addr[1:0]!=0.

State machine:
- IDLE:
  - If any m_req is high, the round-robin winner is chosen, starting the search at rr_ptr.
  - m_gnt for the winner is asserted combinationally in this cycle.
  - At the edge, the winner's channel index, we, mode, addr and wdata are captured.
  - rr_ptr becomes winner+1 mod N_CH.
  - Next state is ISSUE, or ERR if the captured request is illegal or misaligned.
  - If no m_req is high, stay in IDLE.
- ISSUE:
  - mem_addrs, mem_MODE and data_mem_WRITE are driven from captured values.
  - mem_WE equals the captured we; writes commit at this edge.
  - Write: go to RESP.
  - Read with RD_LAT=0: capture data_mem_READ into m_rdata at this edge, go to RESP.
  - Read with RD_LAT>0: load the latency counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Memory outputs are held; mem_WE=0.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture data_mem_READ, go to RESP.
- ERR:
  - No memory access; mem_WE=0.
  - Go to RESP with the error flag set.
- RESP:
  - m_done is a one-cycle pulse on the captured channel.
  - m_err=1 only for the error path.
  - m_rdata holds the read value (unchanged for writes and errors).
  - Next state is IDLE.

Timing:
- Read latency from grant to m_done is RD_LAT+2 cycles; write and error latency is 2 cycles.
- Peak throughput is one transaction per RD_LAT+3 cycles.

Rules and boundary conditions:
- m_gnt is never high outside IDLE.
- At most one bit of m_gnt or m_done is high at a time.
- mem_WE is high only in ISSUE with a captured write.
- A requester dropping m_req before its m_done is a protocol violation; behaviour is unspecified, but the FSM must still complete and return to IDLE.
- Simultaneous requests: with rr_ptr=k, the first requesting channel at or after k (cyclic) wins.
- Pointer wrap: rr_ptr goes from N_CH-1 to 0.
- N_CH=1 degenerates to a pass-through with a fixed winner.
- Reset values (immediate on reset=0, including mid-transaction):
  - state IDLE, rr_ptr 0, counter 0.
  - m_gnt, m_done, m_err all 0; m_rdata 0.
  - mem_WE 0, mem_addrs 0, mem_MODE 3'b010, data_mem_WRITE 0.
- A write interrupted by reset in ISSUE is not guaranteed to have committed.

Decomposition:
- Shared package bean_mem_pkg:
  - mode constants MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU;
  - FSM state encoding IDLE, ISSUE, WAIT, ERR, RESP;
  - the alignment-check function.
- One sub-module, rr_arbiter: N_CH-way combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, winner index and any-valid.

Test Plan:
- RD_LAT=0; ch0 reads LW at 0x100 with memory holding 0xDEADBEEF -> m_gnt[0] in cycle 0, mem_WE=0 in cycle 1, m_done[0]=1 with m_rdata=0xDEADBEEF and m_err=0 in cycle 2.
- ch0 and ch1 request simultaneously and continuously, rr_ptr=0 -> grants alternate ch0, ch1, ch0, ch1; never two grants in one cycle.
- ch1 issues LW at 0x102, then LH at 0x103, then mode 011 -> each gets m_err=1 two cycles after grant; mem_WE stays 0 throughout; memory is untouched.
- ch0 writes SB at 0x200 with wdata 0x000000A5, then LBU at 0x200 -> mem_WE=1 only in the write's ISSUE cycle; the read returns 0x000000A5.
- RD_LAT=3, LW read -> m_done exactly 5 cycles after m_gnt; data is sampled in the last WAIT cycle.
- Reset asserted in WAIT of a read -> all outputs go to reset values immediately; after release, no m_done for the aborted transfer; the next request is granted normally with rr_ptr=0.
